uart_tx_serializer: RTL

UART transmit engine sitting directly downstream of the TX FIFO. Pops bytes from the FIFO through its Read/Data_Out interface, which has 1-cycle registered read latency. Serializes each byte onto the Tx line as an 8N1 frame: start bit, 8 data bits LSB first, 1 stop bit. Bit timing comes from an internal clock-cycle divider.

---
 rtl/uart_tx_serializer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO (1-cycle registered read)
// and serializes each one onto Tx as an 8N1 frame, LSB first. The bit time is
// CLKS_PER_BIT clock cycles.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
// Every output comes from a register, so Tx and Fifo_Read have no
// combinational path from any input.
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Tx_Enable,
  input  logic                  Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data,
  output logic                  Fifo_Read,
  output logic                  Tx,
  output logic                  Tx_Busy,
  output logic                  Tx_Done
);

  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [IDX_WIDTH-1:0]    idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]   shift_right;
`ifdef UART_TX_PARITY_EN
  logic                    parity_reg, parity_next;
`endif

  logic tx_reg, tx_next;
  logic fifo_read_reg, fifo_read_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  logic bit_last;
  logic can_start;

  // A bit ends on the last cycle of the bit counter. A new frame can start
  // only when there is data and the engine is enabled.
  assign bit_last  = (cnt_reg == CNT_LAST);
  assign can_start = Tx_Enable && !Fifo_Empty;

  // Shift register moved one place toward the LSB; a zero fills the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
      if (gi == DATA_WIDTH - 1) begin : g_msb
        assign shift_right[gi] = 1'b0;
      end else begin : g_bit
        assign shift_right[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  // Next-state, datapath and registered-output logic of the frame sequencer.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (can_start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        shift_next  = Fifo_Data;
`ifdef UART_TX_PARITY_EN
        parity_next = ^Fifo_Data;
`endif
        cnt_next    = '0;
        idx_next    = '0;
        state_next  = S_START;
      end
      S_START: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          cnt_next   = '0;
          shift_next = shift_right;
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + IDX_WIDTH'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = can_start ? S_FETCH : S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase

    // The outputs are computed from the next state. Registering them keeps
    // them aligned with the state register and free of input glitches.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase

    fifo_read_next = (state_next == S_FETCH);
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_STOP) && (cnt_next == CNT_LAST);
  end

  // State, datapath and output registers. Reset forces the line high at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
      tx_reg        <= 1'b1;
      fifo_read_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
      tx_reg        <= tx_next;
      fifo_read_reg <= fifo_read_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign Tx        = tx_reg;
  assign Fifo_Read = fifo_read_reg;
  assign Tx_Busy   = busy_reg;
  assign Tx_Done   = done_reg;

endmodule
